// File: rtl/fir_load_sequencer_if.sv
// Host-side streams of the FIR load sequencer: config words, input samples and filtered results.
// The master modport is the host/testbench side; the slave modport is the sequencer.
interface fir_load_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              cfg_start;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DATA_W-1:0] cfg_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_ovf;

  modport master (
    output cfg_start, cfg_valid, cfg_data, s_valid, s_data, m_ready,
    input  cfg_ready, s_ready, m_valid, m_data, m_ovf
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, s_valid, s_data, m_ready,
    output cfg_ready, s_ready, m_valid, m_data, m_ovf
  );
endinterface

// File: rtl/fir_load_sequencer.sv
// Resets, configures and streams samples through an external FIR filter using write strobes.
// Optional result overflow flag: define FIR_SEQ_OVF_CHECK_EN.
module fir_load_sequencer #(
  parameter int TAPS      = 64,
  parameter int DATA_W    = 32,
  parameter int OUT_LAT   = 1,
  parameter int OVF_LIMIT = 511
) (
  input  logic                clk,
  input  logic                reset_n,
  fir_load_sequencer_if.slave bus,
  output logic                flt_rst,
  output logic                flt_coeff_we,
  output logic                flt_sample_we,
  output logic [DATA_W-1:0]   flt_in,
  input  logic [DATA_W-1:0]   flt_out,
  output logic                configured,
  output logic                err_seq
);

  localparam int CNT_W = $clog2(TAPS + 1);

  if (OUT_LAT < 1 || OUT_LAT > 4 || OVF_LIMIT < 0) begin : g_bad_param
    $error("fir_load_sequencer: OUT_LAT must be 1..4 and OVF_LIMIT non-negative");
  end

  typedef enum logic [2:0] {IDLE, RST, COEF, SCALE, RUN} state_t;

  state_t             state, next_state;
  logic               rst_cnt;
  logic [CNT_W-1:0]   coef_idx;
  logic [CNT_W-1:0]   fill;
  logic [OUT_LAT-1:0] pipe;
  logic               m_valid;
  logic [DATA_W-1:0]  m_data;
  logic               cfg_ready, s_ready;
  logic               cfg_fire, s_fire, capture;

  assign cfg_fire = bus.cfg_valid & cfg_ready;
  assign s_fire   = bus.s_valid & s_ready;
  // The single in-flight sample reaches the filter output in the last pipe stage.
  assign capture  = pipe[OUT_LAT-1] && (fill == CNT_W'(TAPS));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every signal written here gets a default first, otherwise an incomplete branch infers a latch.
  always_comb begin
    next_state = state;
    if (bus.cfg_start) begin
      next_state = RST;
    end else begin
      unique case (state)
        IDLE:    next_state = IDLE;
        RST:     if (rst_cnt) next_state = COEF;
        COEF:    if (cfg_fire && coef_idx == CNT_W'(TAPS - 1)) next_state = SCALE;
        SCALE:   if (cfg_fire) next_state = RUN;
        RUN:     next_state = RUN;
        default: next_state = IDLE;
      endcase
    end
  end

  // cfg_start wins over both handshakes, so neither ready may be high in that cycle.
  always_comb begin
    flt_rst       = (state == IDLE) || (state == RST);
    configured    = (state == RUN);
    cfg_ready     = ((state == COEF) || (state == SCALE)) && !bus.cfg_start;
    s_ready       = (state == RUN) && (!m_valid || bus.m_ready) && !(|pipe) && !bus.cfg_start;
    flt_coeff_we  = cfg_fire;
    flt_sample_we = s_fire;
    flt_in        = '0;
    if (cfg_fire)    flt_in = bus.cfg_data;
    else if (s_fire) flt_in = bus.s_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt  <= 1'b0;
      coef_idx <= '0;
      fill     <= '0;
      pipe     <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      err_seq  <= 1'b0;
    end else if (bus.cfg_start) begin
      rst_cnt  <= 1'b0;
      coef_idx <= '0;
      fill     <= '0;
      pipe     <= '0;
      m_valid  <= 1'b0;
      err_seq  <= 1'b0;
    end else begin
      rst_cnt <= (state == RST) && !rst_cnt;
      if (cfg_fire && state == COEF) coef_idx <= coef_idx + CNT_W'(1);
      if (s_fire && fill != CNT_W'(TAPS)) fill <= fill + CNT_W'(1);
      pipe <= (pipe << 1) | OUT_LAT'(s_fire);
      if (capture) begin
        m_valid <= 1'b1;
        m_data  <= flt_out;
      end else if (m_valid && bus.m_ready) begin
        m_valid <= 1'b0;
      end
      if (bus.s_valid && state != RUN) err_seq <= 1'b1;
    end
  end

`ifdef FIR_SEQ_OVF_CHECK_EN
  localparam logic signed [DATA_W-1:0] OVF_HI = DATA_W'(OVF_LIMIT);
  localparam logic signed [DATA_W-1:0] OVF_LO = -OVF_HI;

  logic m_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     m_ovf <= 1'b0;
    else if (capture) m_ovf <= ($signed(flt_out) > OVF_HI) || ($signed(flt_out) < OVF_LO);
  end

  assign bus.m_ovf = m_ovf;
`else
  assign bus.m_ovf = 1'b0;
`endif

  assign bus.cfg_ready = cfg_ready;
  assign bus.s_ready   = s_ready;
  assign bus.m_valid   = m_valid;
  assign bus.m_data    = m_data;

endmodule

// File: tb/tb_fir_load_sequencer.sv
// Directed bench for fir_load_sequencer with a behavioural Q.11 FIR filter on the flt_* side.
module tb_fir_load_sequencer;
  localparam int TAPS    = 64;
  localparam int DW      = 32;
  localparam int OUT_LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flt_rst, flt_coeff_we, flt_sample_we, configured, err_seq;
  logic [DW-1:0] flt_in, flt_out;

  int errors = 0;
  int checks = 0;
  int coef_pulses = 0;
  int mv_count = 0;
  int rst_cycles = 0;

  fir_load_sequencer_if #(.DATA_W(DW)) bus ();

  fir_load_sequencer #(
    .TAPS(TAPS), .DATA_W(DW), .OUT_LAT(OUT_LAT), .OVF_LIMIT(511)
  ) dut (
    .clk(clk), .reset_n(rst_n), .bus(bus),
    .flt_rst(flt_rst), .flt_coeff_we(flt_coeff_we), .flt_sample_we(flt_sample_we),
    .flt_in(flt_in), .flt_out(flt_out), .configured(configured), .err_seq(err_seq)
  );

  always #5 clk = ~clk;

  // Filter model: y = ((sum c[i]*x[n-i]) >>> 11) * scale >>> 11, registered once (OUT_LAT=1).
  logic signed [DW-1:0] coef_mem [TAPS+1];
  logic signed [DW-1:0] dly [TAPS];
  int                   n_coef = 0;
  logic [DW-1:0]        flt_model = '0;
  logic                 force_en = 1'b0;
  logic [DW-1:0]        force_val = '0;

  assign flt_out = force_en ? force_val : flt_model;

  always @(posedge clk) begin
    longint acc;
    if (flt_rst) begin
      n_coef    <= 0;
      flt_model <= '0;
      for (int i = 0; i < TAPS; i++) dly[i] <= '0;
    end else if (flt_coeff_we) begin
      if (n_coef <= TAPS) coef_mem[n_coef] <= flt_in;
      n_coef <= n_coef + 1;
    end else if (flt_sample_we) begin
      acc = longint'(coef_mem[0]) * longint'($signed(flt_in));
      for (int i = 1; i < TAPS; i++) acc += longint'(coef_mem[i]) * longint'(dly[i-1]);
      flt_model <= DW'(((acc >>> 11) * longint'(coef_mem[TAPS])) >>> 11);
      dly[0] <= flt_in;
      for (int i = 1; i < TAPS; i++) dly[i] <= dly[i-1];
    end
  end

  always @(negedge clk) begin
    if (flt_coeff_we) coef_pulses++;
    if (bus.m_valid)  mv_count++;
    if (flt_rst)      rst_cycles++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_start();
    @(posedge clk); #1; bus.cfg_start = 1'b1;
    @(posedge clk); #1; bus.cfg_start = 1'b0;
  endtask

  // Holds cfg_valid for n accepted words: the first coeff_n carry coeff, the rest carry scale.
  task automatic load_words(input int n, input int coeff_n, input logic [DW-1:0] coeff,
                            input logic [DW-1:0] scale);
    int done = 0;
    int guard = 0;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = (coeff_n > 0) ? coeff : scale;
    while (done < n && guard < 400) begin
      @(negedge clk);
      if (bus.cfg_ready) done++;
      guard++;
      if (done < n) begin
        @(posedge clk); #1;
        bus.cfg_data = (done < coeff_n) ? coeff : scale;
      end
    end
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    checks++;
    if (done != n) begin
      errors++; $display("FAIL load_words: accepted %0d words, required %0d", done, n);
    end
  endtask

  task automatic send_sample(input logic [DW-1:0] v, output bit ok);
    int n = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.s_valid = 1'b1;
    bus.s_data  = v;
    while (n < 50) begin
      @(negedge clk);
      if (bus.s_ready) begin ok = 1'b1; break; end
      n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (flt_rst !== 1'b1) begin errors++; $display("FAIL reset_flt_rst: got %b want 1", flt_rst); end
    checks++;
    if ({bus.cfg_ready, bus.s_ready, bus.m_valid, configured, err_seq, flt_coeff_we, flt_sample_we} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {bus.cfg_ready, bus.s_ready, bus.m_valid, configured, err_seq, flt_coeff_we, flt_sample_we});
    end
    checks++;
    if (bus.m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %0h want 0", bus.m_data); end
    rst_n = 1'b1;
    @(posedge clk); #1; bus.s_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.s_ready, flt_sample_we} !== 2'b00) begin
      errors++; $display("FAIL idle_no_sample: ready/we got %b want 00", {bus.s_ready, flt_sample_we});
    end
    @(posedge clk); #1; bus.s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err_seq !== 1'b1) begin errors++; $display("FAIL idle_err_seq: got %b want 1", err_seq); end
    checks++;
    if ({flt_rst, configured} !== 2'b10) begin
      errors++; $display("FAIL idle_state: rst/configured got %b want 10", {flt_rst, configured});
    end
  endtask

  task automatic test_config();
    pulse_start();
    rst_cycles  = 0;
    coef_pulses = 0;
    load_words(TAPS + 1, TAPS, 32'd2048, 32'd1024);
    @(negedge clk);
    checks++;
    if (coef_pulses !== TAPS + 1) begin
      errors++; $display("FAIL config_pulses: got %0d want %0d", coef_pulses, TAPS + 1);
    end
    checks++;
    if (rst_cycles !== 2) begin errors++; $display("FAIL config_rst_cycles: got %0d want 2", rst_cycles); end
    checks++;
    if ({configured, flt_rst, err_seq} !== 3'b100) begin
      errors++; $display("FAIL config_run: configured/rst/err got %b want 100", {configured, flt_rst, err_seq});
    end
    @(posedge clk); #1; bus.cfg_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.cfg_ready, flt_coeff_we} !== 2'b00) begin
      errors++; $display("FAIL run_cfg_ignored: ready/we got %b want 00", {bus.cfg_ready, flt_coeff_we});
    end
    @(posedge clk); #1; bus.cfg_valid = 1'b0;
  endtask

  task automatic test_stream();
    bit ok;
    int n_ok = 0;
    bus.m_ready = 1'b1;
    mv_count = 0;
    for (int i = 1; i < TAPS; i++) begin
      send_sample(32'd1, ok);
      if (ok) n_ok++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (n_ok !== TAPS - 1) begin errors++; $display("FAIL prime_accepts: got %0d want %0d", n_ok, TAPS - 1); end
    checks++;
    if (mv_count !== 0) begin errors++; $display("FAIL prime_no_result: m_valid cycles got %0d want 0", mv_count); end
    bus.m_ready = 1'b0;
    send_sample(32'd1, ok);
    @(negedge clk);
    checks++;
    if ({ok, bus.m_valid, bus.s_ready} !== 3'b100) begin
      errors++; $display("FAIL first_pending: ok/valid/ready got %b want 100", {ok, bus.m_valid, bus.s_ready});
    end
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", bus.m_valid); end
    checks++;
    if ($signed(bus.m_data) < 30 || $signed(bus.m_data) > 34) begin
      errors++; $display("FAIL first_data: got %0d want 32+/-2", $signed(bus.m_data));
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.m_valid, bus.s_ready} !== 2'b10 || bus.m_data !== 32'd32) begin
        errors++;
        $display("FAIL hold_stall: valid/ready got %b data %0d want 10 data 32",
                 {bus.m_valid, bus.s_ready}, bus.m_data);
      end
      @(posedge clk); #1;
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.m_valid, bus.s_ready, flt_sample_we} !== 3'b111 || flt_in !== 32'd5) begin
      errors++;
      $display("FAIL release_same_cycle: valid/ready/we got %b flt_in %0d want 111 flt_in 5",
               {bus.m_valid, bus.s_ready, flt_sample_we}, flt_in);
    end
    @(posedge clk); #1; bus.s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL single_transfer: m_valid got %b want 0", bus.m_valid); end
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 32'd34) begin
      errors++; $display("FAIL second_result: valid %b data %0d want 1 data 34", bus.m_valid, bus.m_data);
    end
  endtask

  task automatic test_abort();
    pulse_start();
    load_words(30, 30, 32'd2048, 32'd1024);
    @(posedge clk); #1; bus.s_valid = 1'b1;
    @(posedge clk); #1;
    bus.cfg_start = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 32'd2048;
    @(negedge clk);
    checks++;
    if (err_seq !== 1'b1) begin errors++; $display("FAIL abort_err_before: got %b want 1", err_seq); end
    checks++;
    if ({bus.cfg_ready, bus.s_ready, flt_coeff_we, flt_sample_we} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_no_strobe: got %b want 0000", {bus.cfg_ready, bus.s_ready, flt_coeff_we, flt_sample_we});
    end
    @(posedge clk); #1;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.s_valid   = 1'b0;
    @(negedge clk);
    checks++;
    if ({flt_rst, err_seq, configured} !== 3'b100) begin
      errors++; $display("FAIL abort_rst: rst/err/configured got %b want 100", {flt_rst, err_seq, configured});
    end
    load_words(TAPS, TAPS, 32'd2048, 32'd1024);
    @(negedge clk);
    checks++;
    if ({bus.cfg_ready, configured} !== 2'b10) begin
      errors++; $display("FAIL abort_index_cleared: ready/configured got %b want 10", {bus.cfg_ready, configured});
    end
    load_words(1, 0, 32'd2048, 32'd1024);
    @(negedge clk);
    checks++;
    if (configured !== 1'b1) begin errors++; $display("FAIL abort_reconfig: got %b want 1", configured); end
  endtask

  task automatic test_ovf();
    bit ok;
    bit seen;
    logic [DW-1:0] vals [3] = '{32'd600, 32'hFFFF_FE00, 32'd511};
    bit exp_ovf [3];
    logic [DW-1:0] got_data;
    logic got_ovf;
`ifdef FIR_SEQ_OVF_CHECK_EN
    exp_ovf = '{1'b1, 1'b1, 1'b0};
`else
    exp_ovf = '{1'b0, 1'b0, 1'b0};
`endif
    bus.m_ready = 1'b1;
    force_en    = 1'b1;
    force_val   = '0;
    for (int i = 1; i < TAPS; i++) send_sample(32'd0, ok);
    for (int k = 0; k < 3; k++) begin
      force_val = vals[k];
      send_sample(32'd0, ok);
      seen = 1'b0;
      got_data = '0;
      got_ovf = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
        @(negedge clk);
        if (bus.m_valid) begin seen = 1'b1; got_data = bus.m_data; got_ovf = bus.m_ovf; end
      end
      checks++;
      if (!seen || got_ovf !== exp_ovf[k] || got_data !== vals[k]) begin
        errors++;
        $display("FAIL ovf_%0d: seen %b ovf %b data %0d want seen 1 ovf %b data %0d",
                 k, seen, got_ovf, $signed(got_data), exp_ovf[k], $signed(vals[k]));
      end
    end
    force_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_config();
    test_stream();
    test_back_to_back();
    test_abort();
    test_ovf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
